// File: rtl/sccb_init_sequencer_if.sv
// Handshake bundle between the init sequencer (master) and the SCCB/I2C byte engine (slave).
interface sccb_init_sequencer_if;
  logic [23:0] i2c_send_dat;
  logic        i2c_sendit;
  logic        i2c_done;
  logic        i2c_nack;
  logic        i2c_clr;

  modport master (output i2c_send_dat, i2c_sendit, i2c_clr, input i2c_done, i2c_nack);
  modport slave  (input i2c_send_dat, i2c_sendit, i2c_clr, output i2c_done, i2c_nack);
endinterface

// File: rtl/sccb_init_sequencer.sv
// Walks an OV5640 register table and feeds the SCCB engine one {addr16,data8} word at a time,
// with NACK/timeout retry, timed delay entries and an END marker.
module sccb_init_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int MAX_RETRY    = 3,
  parameter int DELAY_UNIT   = 1000,
  parameter int GAP_CYCLES   = 4,
  parameter int DONE_TIMEOUT = 4095
) (
  input  logic                  ack_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [23:0]           rom_data,
  sccb_init_sequencer_if.master i2c,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_error,
  output logic [ADDR_W-1:0]     err_index,
  output logic [ADDR_W:0]       entries_sent
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int DW = 8 + $clog2(DELAY_UNIT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WAIT_DONE, S_CHECK, S_GAP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t          state, nxt_state;
  logic            done_p0, done_p1, done_p2;
  logic            nack_p0, nack_p1;
  logic [23:0]     entry_q, cur_entry;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_flag;
  logic [GW-1:0]   gap_cnt;
  logic [DW-1:0]   dly_cnt;
  logic [RW-1:0]   retry_cnt;
  logic            retry_pend;
  logic            is_end, is_dly, done_rise, tmo_hit, chk_fail, can_retry, restart, at_last;

  // A retry replays the latched entry; a fresh fetch decodes the ROM word directly.
  assign cur_entry = retry_pend ? entry_q : rom_data;
  assign is_end    = (cur_entry[23:8] == 16'hFFFE);
  assign is_dly    = (cur_entry[23:8] == 16'hFFFF);
  assign done_rise = done_p1 & ~done_p2;
  assign tmo_hit   = (tmo_cnt == TW'(DONE_TIMEOUT));
  assign chk_fail  = nack_p1 | tmo_flag;
  assign can_retry = (retry_cnt < RW'(MAX_RETRY));
  assign at_last   = (rom_addr == LAST_IDX);
  assign restart   = start & ~abort &
                     ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));

  always_ff @(posedge ack_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    if (abort) nxt_state = S_IDLE;
    else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (start) nxt_state = S_FETCH;
        S_FETCH:     nxt_state = S_DECODE;
        S_DECODE:    nxt_state = is_end ? S_DONE : (is_dly ? S_DELAY : S_WAIT_DONE);
        S_WAIT_DONE: if (done_rise || tmo_hit) nxt_state = S_CHECK;
        S_CHECK: begin
          if (!chk_fail) nxt_state = at_last ? S_DONE : S_GAP;
          else           nxt_state = can_retry ? S_GAP : S_ERROR;
        end
        S_GAP:       if (gap_cnt == '0) nxt_state = retry_pend ? S_DECODE : S_FETCH;
        S_DELAY:     if (dly_cnt == '0) nxt_state = at_last ? S_DONE : S_FETCH;
        default:     nxt_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    init_done      = (state == S_DONE);
    init_error     = (state == S_ERROR);
    i2c.i2c_sendit = (state == S_WAIT_DONE) && !abort;
    i2c.i2c_clr    = abort || restart || ((state == S_CHECK) && chk_fail);
  end

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous done for edge detection.
  always_ff @(posedge ack_clk or posedge reset) begin
    if (reset) begin
      done_p0 <= 1'b0; done_p1 <= 1'b0; done_p2 <= 1'b0;
      nack_p0 <= 1'b0; nack_p1 <= 1'b0;
    end else begin
      done_p0 <= i2c.i2c_done; done_p1 <= done_p0; done_p2 <= done_p1;
      nack_p0 <= i2c.i2c_nack; nack_p1 <= nack_p0;
    end
  end

  always_ff @(posedge ack_clk or posedge reset) begin
    if (reset) begin
      rom_addr         <= '0;
      err_index        <= '0;
      entries_sent     <= '0;
      entry_q          <= '0;
      i2c.i2c_send_dat <= '0;
      tmo_cnt          <= '0;
      tmo_flag         <= 1'b0;
      gap_cnt          <= '0;
      dly_cnt          <= '0;
      retry_cnt        <= '0;
      retry_pend       <= 1'b0;
    end else if (restart) begin
      rom_addr     <= '0;
      err_index    <= '0;
      entries_sent <= '0;
      retry_cnt    <= '0;
      retry_pend   <= 1'b0;
    end else if (!abort) begin
      case (state)
        S_DECODE: begin
          entry_q <= cur_entry;
          if (is_dly) dly_cnt <= DW'(cur_entry[7:0]) * DW'(DELAY_UNIT);
          else if (!is_end) begin
            i2c.i2c_send_dat <= cur_entry;
            tmo_cnt          <= '0;
            tmo_flag         <= 1'b0;
          end
        end
        S_WAIT_DONE: begin
          if (!tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
          tmo_flag <= tmo_hit & ~done_rise;
        end
        S_CHECK: begin
          gap_cnt <= GW'(GAP_CYCLES - 1);
          if (!chk_fail) begin
            entries_sent <= entries_sent + (ADDR_W+1)'(1);
            retry_cnt    <= '0;
            retry_pend   <= 1'b0;
            if (!at_last) rom_addr <= rom_addr + ADDR_W'(1);
          end else if (can_retry) begin
            retry_cnt  <= retry_cnt + RW'(1);
            retry_pend <= 1'b1;
          end else begin
            err_index <= rom_addr;
          end
        end
        S_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        S_DELAY: begin
          if (dly_cnt != '0)  dly_cnt  <= dly_cnt - DW'(1);
          else if (!at_last)  rom_addr <= rom_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer: table-walk model, scripted SCCB engine, per-cycle compare.
module tb_sccb_init_sequencer;
  localparam int ADDR_W       = 8;
  localparam int MAX_RETRY    = 3;
  localparam int DELAY_UNIT   = 10;
  localparam int GAP_CYCLES   = 4;
  localparam int DONE_TIMEOUT = 4095;

  logic              ack_clk = 1'b0;
  logic              reset, start, abort;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data = '0;
  logic              busy, init_done, init_error;
  logic [ADDR_W-1:0] err_index;
  logic [ADDR_W:0]   entries_sent;

  sccb_init_sequencer_if i2c ();

  sccb_init_sequencer #(
    .ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY), .DELAY_UNIT(DELAY_UNIT),
    .GAP_CYCLES(GAP_CYCLES), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .ack_clk(ack_clk), .reset(reset), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .i2c(i2c),
    .busy(busy), .init_done(init_done), .init_error(init_error),
    .err_index(err_index), .entries_sent(entries_sent)
  );

  always #5 ack_clk = ~ack_clk;

  // Synchronous table ROM
  logic [23:0] rom_tbl [0:255];
  always @(posedge ack_clk) rom_data <= rom_tbl[rom_addr];

  // Scripted engine: done 4 cycles after sendit rises, NACK per transaction from nack_seq
  bit nack_seq [0:15];
  bit eng_hang;
  int eng_cnt, eng_txn;
  always @(posedge ack_clk or posedge reset) begin
    if (reset) begin
      i2c.i2c_done <= 1'b0; i2c.i2c_nack <= 1'b0; eng_cnt <= 0; eng_txn <= 0;
    end else begin
      if (i2c.i2c_clr) i2c.i2c_nack <= 1'b0;
      if (!i2c.i2c_sendit) begin
        i2c.i2c_done <= 1'b0; eng_cnt <= 0;
      end else if (!i2c.i2c_done && !eng_hang) begin
        if (eng_cnt == 3) begin
          i2c.i2c_done <= 1'b1;
          if (nack_seq[eng_txn]) i2c.i2c_nack <= 1'b1;
          eng_txn <= eng_txn + 1;
        end else eng_cnt <= eng_cnt + 1;
      end
    end
  end

  int checks = 0, errors = 0;
  bit mon_en = 0, tmo_chk = 0;
  int clr_cnt, sends_cnt;
  logic [23:0] exp_q [$];
  int exp_clr, exp_sent, exp_err_idx;
  bit exp_done, exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++; errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Model: walk the table at entry level using the engine script to decide each attempt.
  task automatic build_model();
    int t, idx, tries;
    bit fin, ok;
    logic [23:0] e;
    t = 0; idx = 0; fin = 0;
    exp_q.delete();
    exp_clr = 1; exp_done = 0; exp_err = 0; exp_err_idx = 0; exp_sent = 0;
    while (!fin && idx < 256) begin
      e = rom_tbl[idx];
      if (e[23:8] == 16'hFFFE) begin exp_done = 1; fin = 1; end
      else if (e[23:8] == 16'hFFFF) idx++;
      else begin
        tries = 0; ok = 0;
        while (!ok && tries <= MAX_RETRY) begin
          exp_q.push_back(e);
          ok = !eng_hang && !nack_seq[t];
          t++; tries++;
          if (!ok) exp_clr++;
        end
        if (ok) begin exp_sent++; idx++; end
        else begin exp_err = 1; exp_err_idx = idx; fin = 1; end
      end
    end
  endtask

  task automatic monitor();
    logic prev = 0, first = 1;
    int low_cnt = 0, hi_len = 0;
    logic [23:0] held = '0;
    forever begin
      @(negedge ack_clk);
      if (mon_en) begin
        if (i2c.i2c_clr) clr_cnt++;
        check("done_and_error", {31'd0, init_done & init_error}, 32'd0);
        if (i2c.i2c_sendit && !prev) begin
          sends_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_txn: got %0h expected none", i2c.i2c_send_dat);
          end else check("send_dat", {8'd0, i2c.i2c_send_dat}, {8'd0, exp_q.pop_front()});
          if (!first) check("gap_ge_min", {31'd0, low_cnt >= GAP_CYCLES}, 32'd1);
          check("busy_in_txn", {31'd0, busy}, 32'd1);
          first = 0; held = i2c.i2c_send_dat; hi_len = 0;
        end else if (i2c.i2c_sendit) begin
          check("dat_stable", {8'd0, i2c.i2c_send_dat}, {8'd0, held});
        end
        if (!i2c.i2c_sendit && prev && tmo_chk)
          check("timeout_len", {31'd0, hi_len >= DONE_TIMEOUT && hi_len <= DONE_TIMEOUT + 5}, 32'd1);
        if (i2c.i2c_sendit) begin hi_len++; low_cnt = 0; end
        else low_cnt++;
        prev = i2c.i2c_sendit;
      end else begin
        prev = 0; first = 1; low_cnt = 0; hi_len = 0;
      end
    end
  endtask

  task automatic do_reset();
    mon_en = 0; start = 0; abort = 0;
    reset = 1;
    repeat (2) @(posedge ack_clk);
    #1 reset = 0;
  endtask

  task automatic load_table(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    for (int i = 0; i < 256; i++) rom_tbl[i] = 24'hFFFE00;
    rom_tbl[0] = a; rom_tbl[1] = b; rom_tbl[2] = c;
  endtask

  task automatic set_nacks(input logic [15:0] m);
    for (int i = 0; i < 16; i++) nack_seq[i] = m[i];
  endtask

  task automatic run_walk(input string tag, input int budget, input bit busy_start, output int cycles);
    build_model();
    clr_cnt = 0; sends_cnt = 0;
    @(posedge ack_clk); #1;
    mon_en = 1; start = 1;
    @(posedge ack_clk); #1 start = 0;
    cycles = 0;
    while (!(init_done || init_error) && cycles < budget) begin
      @(negedge ack_clk);
      cycles++;
      start = busy_start && (cycles == 10);
    end
    start = 0;
    if (cycles >= budget) fail_bound({tag, "_walk"});
    @(negedge ack_clk);
    check({tag, "_done"},      {31'd0, init_done},  {31'd0, exp_done});
    check({tag, "_error"},     {31'd0, init_error}, {31'd0, exp_err});
    check({tag, "_err_index"}, {24'd0, err_index},  exp_err_idx);
    check({tag, "_sent"},      {23'd0, entries_sent}, exp_sent);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
    check({tag, "_clr_cnt"},   clr_cnt, exp_clr);
    check({tag, "_left_txn"},  exp_q.size(), 32'd0);
    mon_en = 0;
  endtask

  task automatic wait_sendit(input string tag, input logic [23:0] want, input int budget);
    int n = 0;
    while (!(i2c.i2c_sendit && i2c.i2c_send_dat == want) && n < budget) begin
      @(negedge ack_clk); n++;
    end
    if (n >= budget) fail_bound(tag);
  endtask

  initial begin
    int cyc, t0, t5;
    fork monitor(); join_none
    eng_hang = 0; set_nacks(16'h0000);
    load_table(24'h300842, 24'h310303, 24'hFFFE00);
    start = 0; abort = 0; reset = 1;
    #2;
    check("rst_sendit", {31'd0, i2c.i2c_sendit}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, init_done}, 32'd0);
    check("rst_error",  {31'd0, init_error}, 32'd0);
    check("rst_sent",   {23'd0, entries_sent}, 32'd0);
    check("rst_addr",   {24'd0, rom_addr}, 32'd0);
    do_reset();

    // Clean walk, with a start pulse mid-walk that must be ignored
    run_walk("t1", 500, 1'b1, cyc);
    check("t1_sent_lit", {23'd0, entries_sent}, 32'd2);
    check("t1_sends_lit", sends_cnt, 32'd2);

    // Entry 1 NACKs twice then acks
    do_reset(); set_nacks(16'b0110);
    run_walk("t2", 1000, 1'b0, cyc);
    check("t2_clr_lit", clr_cnt, 32'd3);
    check("t2_sends_lit", sends_cnt, 32'd4);
    check("t2_done_lit", {31'd0, init_done}, 32'd1);

    // Entry 1 always NACKs
    do_reset(); set_nacks(16'hFFFE);
    run_walk("t3", 1000, 1'b0, cyc);
    check("t3_err_lit", {31'd0, init_error}, 32'd1);
    check("t3_idx_lit", {24'd0, err_index}, 32'd1);
    check("t3_sent_lit", {23'd0, entries_sent}, 32'd1);
    check("t3_sends_lit", sends_cnt, 32'd5);

    // Delay entries: 5 units of 10 cycles versus 0 units
    do_reset(); set_nacks(16'h0000);
    load_table(24'hFFFF00, 24'hFFFE00, 24'hFFFE00);
    run_walk("t4a", 500, 1'b0, t0);
    do_reset();
    load_table(24'hFFFF05, 24'hFFFE00, 24'hFFFE00);
    run_walk("t4b", 500, 1'b0, t5);
    check("t4_delay_delta", t5 - t0, 32'd50);
    check("t4_sends_lit", sends_cnt, 32'd0);

    // Engine never answers: every attempt times out
    do_reset(); eng_hang = 1; tmo_chk = 1;
    load_table(24'h300842, 24'hFFFE00, 24'hFFFE00);
    run_walk("t5", 25000, 1'b0, cyc);
    tmo_chk = 0;
    check("t5_err_lit", {31'd0, init_error}, 32'd1);
    check("t5_sends_lit", sends_cnt, 32'd4);

    // Abort mid WAIT_DONE
    do_reset();
    exp_q.delete(); exp_q.push_back(24'h300842);
    clr_cnt = 0; sends_cnt = 0;
    @(posedge ack_clk); #1 mon_en = 1; start = 1;
    @(posedge ack_clk); #1 start = 0;
    wait_sendit("t6_wait", 24'h300842, 100);
    repeat (5) @(negedge ack_clk);
    @(posedge ack_clk); #1 abort = 1;
    @(negedge ack_clk);
    check("t6_sendit_same", {31'd0, i2c.i2c_sendit}, 32'd0);
    @(posedge ack_clk); #1 abort = 0;
    @(negedge ack_clk);
    check("t6_sendit", {31'd0, i2c.i2c_sendit}, 32'd0);
    check("t6_busy",   {31'd0, busy}, 32'd0);
    check("t6_done",   {31'd0, init_done}, 32'd0);
    check("t6_error",  {31'd0, init_error}, 32'd0);
    check("t6_clr_lit", clr_cnt, 32'd2);
    mon_en = 0;

    // Asynchronous reset during the second transaction
    do_reset(); eng_hang = 0;
    load_table(24'h300842, 24'h310303, 24'hFFFE00);
    @(posedge ack_clk); #1 start = 1;
    @(posedge ack_clk); #1 start = 0;
    wait_sendit("t7_wait", 24'h310303, 200);
    check("t7_pre_sent", {23'd0, entries_sent}, 32'd1);
    #2 reset = 1;
    #1;
    check("t7_sendit", {31'd0, i2c.i2c_sendit}, 32'd0);
    check("t7_busy",   {31'd0, busy}, 32'd0);
    check("t7_addr",   {24'd0, rom_addr}, 32'd0);
    check("t7_sent",   {23'd0, entries_sent}, 32'd0);
    check("t7_dat",    {8'd0, i2c.i2c_send_dat}, 32'd0);
    check("t7_done",   {31'd0, init_done | init_error}, 32'd0);
    repeat (2) @(posedge ack_clk);
    #1 reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Walks an OV5640 register table and drives the SCCB/I2C byte engine one 24-bit transaction at a time: {reg_addr[15:0], reg_data[7:0]}.
- Handles per-transaction completion, NACK retry, timed delay entries and end-of-table.
- Sits between the camera bring-up control logic and the i2c engine, replacing fixed hard-coded step lists.
- Reports init_done or init_error to the VGA/camera top level.

Parameters:
- ADDR_W, 8, table index width; maximum table depth is 2**ADDR_W entries.
- MAX_RETRY, 3, extra attempts allowed per entry after a NACK (total attempts = MAX_RETRY+1).
- DELAY_UNIT, 1000, ack_clk cycles per delay-entry count.
- GAP_CYCLES, 4, idle cycles with i2c_sendit low between transactions (min 1).
- DONE_TIMEOUT, 4095, maximum cycles to wait for i2c_done before the attempt is treated as a NACK.

Ports:
- ack_clk  in  1  sequencer clock
- reset  in  1  async active-high reset
- start  in  1  1-cycle pulse: begin table walk from index 0
- abort  in  1  1-cycle pulse: stop walk, go IDLE
- rom_addr  out  ADDR_W  table index
- rom_data  in  24  table entry; valid 1 cycle after rom_addr changes
- i2c_send_dat  out  24  word to the i2c engine
- i2c_sendit  out  1  level request to the i2c engine
- i2c_done  in  1  engine transaction complete (level)
- i2c_nack  in  1  engine sticky NACK flag
- i2c_clr  out  1  1-cycle pulse clearing the engine NACK flag
- busy  out  1  walk in progress
- init_done  out  1  table completed successfully (sticky until start/reset)
- init_error  out  1  entry failed all retries (sticky until start/reset)
- err_index  out  ADDR_W  index of the failing entry
- entries_sent  out  ADDR_W+1  count of successfully written entries

Behaviour:
- Reset (async): all outputs 0, state IDLE, counters 0.
- Inputs i2c_done and i2c_nack are two-flop synchronised into ack_clk. All decisions use the synchronised copies, so they add 2 cycles of latency.
- Entry decode:
  - reg_addr 16'hFFFF: DELAY entry, waits reg_data*DELAY_UNIT cycles; reg_data 0 gives 0 cycles.
  - reg_addr 16'hFFFE: END marker.
  - Any other value: WRITE entry.
- States and transitions:
  - IDLE: on start, clear init_done, init_error, err_index and entries_sent; set rom_addr=0; pulse i2c_clr; go to FETCH. busy is 1 in every state except IDLE, DONE and ERROR.
  - FETCH: wait 1 cycle for rom_data; latch the entry; go to DECODE.
  - DECODE:
    - END: go to DONE.
    - DELAY: load the delay counter; go to DELAY.
    - WRITE: drive i2c_send_dat, set i2c_sendit=1, clear the timeout counter; go to WAIT_DONE.
  - WAIT_DONE:
    - Hold i2c_sendit=1 and i2c_send_dat stable.
    - On the rising edge of synchronised i2c_done, drop i2c_sendit and go to CHECK.
    - If the timeout counter reaches DONE_TIMEOUT, drop i2c_sendit and go to CHECK with a forced-NACK flag set.
  - CHECK:
    - NACK clear and no timeout: entries_sent+1, rom_addr+1, reset the retry counter, go to GAP.
    - NACK set or timeout: pulse i2c_clr.
      - If retries < MAX_RETRY: retries+1, go to GAP, then resend the same entry.
      - Otherwise: err_index=rom_addr, go to ERROR.
  - GAP: hold i2c_sendit=0 for GAP_CYCLES, then go to FETCH. On a retry, go to DECODE using the latched entry instead.
  - DELAY: count down to 0, then rom_addr+1, go to FETCH.
  - DONE: init_done=1; stay until start.
  - ERROR: init_error=1; stay until start.
- rom_addr wrap: if the index reaches 2**ADDR_W-1 without an END marker, that entry is processed and the walk then goes to DONE. rom_addr never wraps to 0.
- Priority: abort overrides everything except reset. On abort: i2c_sendit=0 the same cycle, one i2c_clr pulse, go to IDLE, init_done and init_error left at 0.
- start while busy is ignored. start in DONE or ERROR restarts the walk.
- start and abort in the same cycle: abort wins.
- Reset mid-transaction: i2c_sendit drops asynchronously.

Test Plan:
- Table {300842, 310303, FFFE00}, engine acks all -> 2 transactions with i2c_send_dat 24'h300842 then 24'h310303; i2c_sendit low ≥4 cycles between them; init_done=1; entries_sent=2.
- Entry 1 NACKs twice then acks (MAX_RETRY=3) -> 24'h310303 sent 3 times; 3 i2c_clr pulses total (start plus 2 NACKs); init_done=1; init_error=0.
- Entry 1 always NACKs -> 4 attempts; init_error=1; err_index=1; entries_sent=1; busy=0.
- Table {FFFF05, FFFE00}, DELAY_UNIT=10 -> no i2c_sendit; init_done asserts 50 cycles (±fixed pipeline overhead) after FETCH of entry 0.
- i2c_done held low -> after 4095 cycles, treated as a NACK and retried; all attempts exhaust -> init_error=1.
- abort asserted mid-WAIT_DONE -> i2c_sendit=0 next edge; busy=0; init_done and init_error both 0. Reset mid-walk -> all outputs 0 immediately.
